// File: rtl/uart_frame_ctrl.sv
// Frame sequencer: SYNC, LEN, payload (and optional checksum) steered into the sample buffer.
// Optional checksum byte is compiled in when UART_FRAME_CKSUM_EN is defined.
module uart_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned TIMEOUT_CLKS = 17360
) (
  input  logic                  i_Clock,
  input  logic                  i_Rst_n,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  output logic                  o_Wr_En,
  output logic [ADDR_WIDTH-1:0] o_Wr_Addr,
  output logic [7:0]            o_Wr_Data,
  output logic                  o_Frame_Done,
  output logic                  o_Frame_Err,
  output logic [7:0]            o_Frame_Len,
  output logic                  o_Busy
);

  localparam int unsigned   TW       = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 2);
  localparam logic [32:0]   MAX_LEN  = 33'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CKSUM, DONE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            len_q;
  logic [7:0]            idx_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [TW-1:0]         tmo_q;

  logic take, start, err, done;
  logic last, len_bad, tmo_hit;

`ifdef UART_FRAME_CKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_chk;
  assign sum_chk = sum_q + i_Rx_Byte;
`endif

  assign last    = (idx_q == len_q - 8'd1);
  assign len_bad = (i_Rx_Byte == '0) || (33'(i_Rx_Byte) > MAX_LEN);
  // The timer counts the clock one before expiry, so the error pulse lands
  // TIMEOUT_CLKS clocks after the strobe; a byte arriving on that clock wins.
  assign tmo_hit = !i_Rx_DV && (state_q != IDLE) && (state_q != DONE) && (tmo_q == TMO_LAST);
  assign o_Busy  = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    start   = 1'b0;
    err     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) state_d = LEN;
      end
      LEN: begin
        if (i_Rx_DV) begin
          if (len_bad) begin
            err     = 1'b1;
            state_d = IDLE;
          end else begin
            start   = 1'b1;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (i_Rx_DV) begin
          take = 1'b1;
`ifdef UART_FRAME_CKSUM_EN
          if (last) state_d = CKSUM;
`else
          if (last) state_d = DONE;
`endif
        end
      end
`ifdef UART_FRAME_CKSUM_EN
      CKSUM: begin
        if (i_Rx_DV) begin
          if (sum_chk == '0) begin
            state_d = DONE;
          end else begin
            err     = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (tmo_hit) begin
      err     = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Wr_En      <= 1'b0;
      o_Wr_Addr    <= '0;
      o_Wr_Data    <= '0;
      o_Frame_Done <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Frame_Len  <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      addr_q       <= '0;
      tmo_q        <= '0;
`ifdef UART_FRAME_CKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      o_Wr_En      <= take;
      o_Frame_Done <= done;
      o_Frame_Err  <= err;
      if (start) begin
        len_q  <= i_Rx_Byte;
        idx_q  <= '0;
        addr_q <= '0;
`ifdef UART_FRAME_CKSUM_EN
        sum_q  <= i_Rx_Byte;
`endif
      end
      if (take) begin
        o_Wr_Addr <= addr_q;
        o_Wr_Data <= i_Rx_Byte;
        addr_q    <= addr_q + 1'b1;
        idx_q     <= idx_q + 8'd1;
`ifdef UART_FRAME_CKSUM_EN
        sum_q     <= sum_chk;
`endif
      end
      if (done) o_Frame_Len <= len_q;
      if (i_Rx_DV || (state_d == IDLE)) tmo_q <= '0;
      else                              tmo_q <= tmo_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: vector table plus timeout and reset sequences.
// Honours UART_FRAME_CKSUM_EN to match the build of the design.
module tb_uart_frame_ctrl;

  localparam int unsigned AW  = 4;
  localparam int unsigned TMO = 24;
  localparam int          NV  = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          frame_done;
  logic          frame_err;
  logic [7:0]    frame_len;
  logic          busy;

  always #5 clk = ~clk;

  uart_frame_ctrl #(
    .SYNC_BYTE(8'hA5),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .i_Clock(clk),
    .i_Rst_n(rst_n),
    .i_Rx_DV(rx_dv),
    .i_Rx_Byte(rx_byte),
    .o_Wr_En(wr_en),
    .o_Wr_Addr(wr_addr),
    .o_Wr_Data(wr_data),
    .o_Frame_Done(frame_done),
    .o_Frame_Err(frame_err),
    .o_Frame_Len(frame_len),
    .o_Busy(busy)
  );

  typedef struct {
    string        name;
    int           n_in;
    logic [159:0] in_bytes;
    int           n_wr;
    logic [127:0] wr_bytes;
    int           n_done;
    int           n_err;
    logic [7:0]   len_after;
  } vec_t;

  vec_t vecs[NV];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [AW-1:0] mon_addr[$];
  logic [7:0]    mon_data[$];
  int n_done, n_err, last_dv_cyc, done_cyc, err_cyc;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input int n_in, input logic [159:0] in_b,
                              input int n_wr, input logic [127:0] wr_b, input int nd,
                              input int ne, input logic [7:0] len);
    vec_t v;
    v.name = name; v.n_in = n_in; v.in_bytes = in_b; v.n_wr = n_wr; v.wr_bytes = wr_b;
    v.n_done = nd; v.n_err = ne; v.len_after = len;
    return v;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_dv) last_dv_cyc = cyc;
    if (wr_en) begin
      mon_addr.push_back(wr_addr);
      mon_data.push_back(wr_data);
    end
    if (frame_done) begin n_done++; done_cyc = cyc; end
    if (frame_err)  begin n_err++;  err_cyc  = cyc; end
    if (frame_done || frame_err) check("done_err_exclusive", longint'(frame_done & frame_err), 0);
  end

  task automatic clear_mon();
    mon_addr.delete();
    mon_data.delete();
    n_done = 0; n_err = 0; last_dv_cyc = 0; done_cyc = 0; err_cyc = 0;
  endtask

  // Caller sits #1 after a rising edge; the byte is sampled on the next edge.
  task automatic send_byte(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_dv = 1'b0; rx_byte = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_writes(input string name, input int n, input logic [127:0] exp_b);
    check({name, "_nwr"}, mon_data.size(), n);
    for (int j = 0; j < n && j < mon_data.size(); j++) begin
      check({name, "_addr"}, mon_addr[j], j);
      check({name, "_data"}, mon_data[j], exp_b[8*(n-1-j) +: 8]);
    end
  endtask

  initial begin
    vec_t v;
`ifdef UART_FRAME_CKSUM_EN
    vecs[0] = mk("good",      6, 48'hA5_03_10_20_30_9D, 3, 24'h10_20_30, 1, 0, 8'h03);
    vecs[1] = mk("bad_cksum", 6, 48'hA5_03_10_20_30_9C, 3, 24'h10_20_30, 0, 1, 8'h03);
    vecs[2] = mk("zero_len",  4, 32'h00_FF_A5_00,       0, '0,           0, 1, 8'h03);
    vecs[3] = mk("len_over",  2, 16'hA5_11,             0, '0,           0, 1, 8'h03);
    vecs[4] = mk("len_max",  19,
                 152'hA5_10_01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10_68, 16,
                 128'h01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10, 1, 0, 8'h10);
    vecs[5] = mk("sync_data", 5, 40'hA5_02_A5_A5_B4,    2, 16'hA5_A5,    1, 0, 8'h02);
`else
    vecs[0] = mk("good",      5, 40'hA5_03_10_20_30,    3, 24'h10_20_30, 1, 0, 8'h03);
    vecs[1] = mk("two",       4, 32'hA5_02_AA_BB,       2, 16'hAA_BB,    1, 0, 8'h02);
    vecs[2] = mk("zero_len",  4, 32'h00_FF_A5_00,       0, '0,           0, 1, 8'h02);
    vecs[3] = mk("len_over",  2, 16'hA5_11,             0, '0,           0, 1, 8'h02);
    vecs[4] = mk("len_max",  18,
                 144'hA5_10_01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10, 16,
                 128'h01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10, 1, 0, 8'h10);
    vecs[5] = mk("sync_data", 4, 32'hA5_02_A5_A5,       2, 16'hA5_A5,    1, 0, 8'h02);
`endif

    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_len", frame_len, 0);
    rst_n = 1'b1;
    idle(2);

    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
      clear_mon();
      for (int i = 0; i < v.n_in; i++) begin
        send_byte(v.in_bytes[8*(v.n_in-1-i) +: 8]);
        idle(3);
      end
      idle(6);
      check_writes(v.name, v.n_wr, v.wr_bytes);
      check({v.name, "_done"}, n_done, v.n_done);
      check({v.name, "_err"}, n_err, v.n_err);
      check({v.name, "_len"}, frame_len, v.len_after);
      check({v.name, "_busy"}, busy, 0);
      if (v.n_done == 1 && n_done == 1)
        check({v.name, "_done_lat"}, done_cyc - last_dv_cyc, 2);
    end

    // Truncated frame: error exactly TMO clocks after the last strobe.
    clear_mon();
    send_byte(8'hA5); idle(3); send_byte(8'h04); idle(3);
    send_byte(8'h11); idle(3); send_byte(8'h22);
    idle(TMO + 4);
    check_writes("tmo", 2, 16'h11_22);
    check("tmo_err", n_err, 1);
    check("tmo_done", n_done, 0);
    if (n_err == 1) check("tmo_err_lat", err_cyc - last_dv_cyc, TMO);
    check("tmo_busy", busy, 0);
    check("tmo_len", frame_len, 8'h02);
    clear_mon();
    send_byte(8'hA5); idle(3); send_byte(8'h01); idle(3); send_byte(8'hA5); idle(3);
`ifdef UART_FRAME_CKSUM_EN
    send_byte(8'h5A); idle(3);
`endif
    idle(6);
    check_writes("after_tmo", 1, 8'hA5);
    check("after_tmo_done", n_done, 1);
    check("after_tmo_err", n_err, 0);
    check("after_tmo_len", frame_len, 8'h01);

    // Gaps right at the limit: byte arrives on the expiry clock and wins.
    clear_mon();
    send_byte(8'hA5); idle(3); send_byte(8'h02); idle(TMO - 2);
    send_byte(8'h11); idle(TMO - 2); send_byte(8'h22);
`ifdef UART_FRAME_CKSUM_EN
    idle(3); send_byte(8'hCB);
`endif
    idle(6);
    check_writes("edge_gap", 2, 16'h11_22);
    check("edge_gap_err", n_err, 0);
    check("edge_gap_done", n_done, 1);
    check("edge_gap_len", frame_len, 8'h02);

    // One clock longer: timeout in LEN state.
    clear_mon();
    send_byte(8'hA5); idle(TMO - 1);
    idle(3);
    check("len_tmo_err", n_err, 1);
    check("len_tmo_busy", busy, 0);

    // Asynchronous reset mid-frame.
    clear_mon();
    send_byte(8'hA5); idle(3); send_byte(8'h02); idle(3); send_byte(8'h11); idle(2);
    check("pre_rst_data", wr_data, 8'h11);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_addr", wr_addr, 0);
    check("mid_rst_data", wr_data, 0);
    check("mid_rst_done", frame_done, 0);
    check("mid_rst_err", frame_err, 0);
    check("mid_rst_len", frame_len, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    clear_mon();
    send_byte(8'hA5); idle(3); send_byte(8'h01); idle(3); send_byte(8'h7E); idle(3);
`ifdef UART_FRAME_CKSUM_EN
    send_byte(8'h81); idle(3);
`endif
    idle(6);
    check_writes("post_rst", 1, 8'h7E);
    check("post_rst_done", n_done, 1);
    check("post_rst_err", n_err, 0);
    check("post_rst_len", frame_len, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
